instruction_fetch: RTL and testbench

Instruction fetch unit for the single-core processor. It owns the program counter, drives the 5-bit address of the 32x32 program memory, and captures the instruction word returned combinationally on the same cycle. JUMP is resolved locally and never forwarded. Every other instruction, including HALT, is handed to the execute stage through a valid/ready register slot.

---
 rtl/instruction_fetch.sv | 118 +++++++++++
 tb/tb_instruction_fetch.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Owns the program counter and fetches one word per load cycle from a
//   combinational program memory. JUMP is resolved here and never forwarded;
//   every other word (HALT included) is handed to execute through a
//   valid/ready register slot.
//
// Ports
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : leave IDLE and begin fetching at address 0
//   pmem_add     : program memory address (always equals pc)
//   pmem_data    : word at pmem_add, valid in the same cycle
//   instr        : registered instruction for execute
//   instr_valid  : instr holds an unconsumed instruction
//   instr_ready  : execute accepts instr this cycle
//   pc           : current fetch address
//   halted       : HALT has been captured; fetching has stopped
//   issued       : count of completed instr handshakes (wraps)
module instruction_fetch #(
  parameter int          ADDR_W  = 5,
  parameter int          DATA_W  = 32,
  parameter logic [4:0]  HALT_OP = 5'b10000,
  parameter logic [4:0]  JUMP_OP = 5'b10001,
  parameter int          CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] pmem_add,
  input  logic [DATA_W-1:0] pmem_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [CNT_W-1:0]  issued
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                halted_q, halted_d;
  logic [CNT_W-1:0]    issued_q, issued_d;

  logic                fire;
  logic                load;
  logic [4:0]          opcode;
  logic signed [4:0]   jmp_off;

  assign opcode  = pmem_data[31:27];
  assign jmp_off = $signed(pmem_data[16:12]);
  assign fire    = instr_valid_q && instr_ready;
  // The slot can take a new word when empty or being drained this edge.
  assign load    = (state_q == RUN) && (!instr_valid_q || instr_ready);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    halted_d      = halted_q;
    issued_d      = issued_q + CNT_W'(fire);
    // A consumed word leaves the slot empty unless a load refills it below.
    instr_valid_d = instr_valid_q && !instr_ready;

    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (load) begin
          if (opcode == JUMP_OP) begin
            // Target is relative to the word after the JUMP; wraps mod 2^ADDR_W.
            pc_d          = pc_q + ADDR_W'(1) + ADDR_W'(jmp_off);
            instr_valid_d = 1'b0;
          end else if (opcode == HALT_OP) begin
            instr_d       = pmem_data;
            instr_valid_d = 1'b1;
            halted_d      = 1'b1;
            state_d       = HALTED;
          end else begin
            instr_d       = pmem_data;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + ADDR_W'(1);
          end
        end
      end
      default: ; // HALTED: only the pending HALT word drains; reset exits.
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      issued_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      issued_q      <= issued_d;
    end
  end

  assign pmem_add    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign issued      = issued_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [4:0] ADD  = 5'b00001;
  localparam logic [4:0] ADC  = 5'b00010;
  localparam logic [4:0] SUB  = 5'b00011;
  localparam logic [4:0] HALT = 5'b10000;
  localparam logic [4:0] JUMP = 5'b10001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  pmem_add;
  logic [31:0] pmem_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  pc;
  logic        halted;
  logic [15:0] issued;

  logic [31:0] mem [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign pmem_data = mem[pmem_add];

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pmem_add(pmem_add),
    .pmem_data(pmem_data), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .halted(halted), .issued(issued)
  );

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] off, input logic [11:0] tag);
    return {op, 10'b0, off, tag};
  endfunction

  // Fill memory with distinct ADD words so any stray fetch is visible.
  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = mk(ADD, 5'd0, 12'hA00 + 12'(i));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic seq_prog();
    clear_mem();
    mem[0] = mk(ADD, 5'd0, 12'h100);
    mem[1] = mk(ADC, 5'd0, 12'h101);
    mem[2] = mk(SUB, 5'd0, 12'h102);
    mem[3] = mk(HALT, 5'd0, 12'h103);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; instr_ready = 1'b1;
    tick(); tick();
    checks++; if (pc !== 5'd0) begin errors++; $display("FAIL reset_pc got %0d exp 0", pc); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if (instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    checks++; if (issued !== 16'd0) begin errors++; $display("FAIL reset_issued got %0d exp 0", issued); end
    rst_n = 1'b1; start = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b0 || pc !== 5'd0) begin errors++; $display("FAIL idle_nofetch got valid=%b pc=%0d exp 0/0", instr_valid, pc); end
  endtask

  task automatic test_sequential();
    seq_prog(); do_reset();
    instr_ready = 1'b1;
    do_start();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_e0_valid got %b exp 0", instr_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (instr !== mem[i] || instr_valid !== 1'b1) begin errors++; $display("FAIL seq_word%0d got %h/%b exp %h/1", i, instr, instr_valid, mem[i]); end
      checks++; if (halted !== (i == 3)) begin errors++; $display("FAIL seq_halted%0d got %b exp %b", i, halted, (i == 3)); end
    end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_drain got %b exp 0", instr_valid); end
    checks++; if (pc !== 5'd3) begin errors++; $display("FAIL seq_pc got %0d exp 3", pc); end
    checks++; if (issued !== 16'd4) begin errors++; $display("FAIL seq_issued got %0d exp 4", issued); end
  endtask

  task automatic test_jump();
    clear_mem();
    mem[0] = mk(ADD, 5'd0, 12'h200);
    mem[1] = mk(JUMP, 5'b00010, 12'h201);
    mem[4] = mk(SUB, 5'd0, 12'h204);
    mem[5] = mk(HALT, 5'd0, 12'h205);
    do_reset();
    instr_ready = 1'b1;
    do_start();
    tick();
    checks++; if (instr !== mem[0] || instr_valid !== 1'b1) begin errors++; $display("FAIL jmp_w0 got %h/%b exp %h/1", instr, instr_valid, mem[0]); end
    tick();
    checks++; if (instr_valid !== 1'b0 || pc !== 5'd4) begin errors++; $display("FAIL jmp_bubble got valid=%b pc=%0d exp 0/4", instr_valid, pc); end
    tick();
    checks++; if (instr !== mem[4] || instr_valid !== 1'b1) begin errors++; $display("FAIL jmp_w4 got %h/%b exp %h/1", instr, instr_valid, mem[4]); end
    tick();
    checks++; if (instr !== mem[5] || halted !== 1'b1 || pc !== 5'd5) begin errors++; $display("FAIL jmp_w5 got %h/%b/%0d exp %h/1/5", instr, halted, pc, mem[5]); end
    tick();
    checks++; if (issued !== 16'd3 || instr_valid !== 1'b0) begin errors++; $display("FAIL jmp_issued got %0d/%b exp 3/0", issued, instr_valid); end
  endtask

  task automatic test_backpressure();
    seq_prog(); do_reset();
    instr_ready = 1'b0;
    do_start();
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr !== mem[0] || instr_valid !== 1'b1 || pc !== 5'd1 || pmem_add !== 5'd1) begin
        errors++; $display("FAIL bp_hold%0d got %h/%b/%0d/%0d exp %h/1/1/1", i, instr, instr_valid, pc, pmem_add, mem[0]);
      end
    end
    instr_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++; if (instr !== mem[i] || instr_valid !== 1'b1) begin errors++; $display("FAIL bp_word%0d got %h/%b exp %h/1", i, instr, instr_valid, mem[i]); end
    end
    tick();
    checks++; if (issued !== 16'd4 || instr_valid !== 1'b0) begin errors++; $display("FAIL bp_issued got %0d/%b exp 4/0", issued, instr_valid); end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[0]  = mk(JUMP, 5'b11110, 12'h300);
    mem[31] = mk(HALT, 5'd0, 12'h31F);
    do_reset();
    instr_ready = 1'b1;
    do_start();
    tick();
    checks++; if (pc !== 5'd31 || instr_valid !== 1'b0) begin errors++; $display("FAIL wrap_pc got %0d/%b exp 31/0", pc, instr_valid); end
    tick();
    checks++; if (instr !== mem[31] || halted !== 1'b1 || pc !== 5'd31) begin errors++; $display("FAIL wrap_halt got %h/%b/%0d exp %h/1/31", instr, halted, pc, mem[31]); end
  endtask

  task automatic test_reset_mid();
    seq_prog(); do_reset();
    instr_ready = 1'b1;
    do_start();
    tick(); tick();
    instr_ready = 1'b0;
    tick();
    checks++; if (issued !== 16'd1 || instr !== mem[1] || instr_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got %0d/%h exp 1/%h", issued, instr, mem[1]); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (instr_valid !== 1'b0 || pc !== 5'd0 || issued !== 16'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL rmid_post got %b/%0d/%0d/%b exp 0/0/0/0", instr_valid, pc, issued, halted);
    end
    instr_ready = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b0 || pc !== 5'd0) begin errors++; $display("FAIL rmid_idle got %b/%0d exp 0/0", instr_valid, pc); end
    do_start();
    tick();
    checks++; if (instr !== mem[0] || instr_valid !== 1'b1) begin errors++; $display("FAIL rmid_refetch got %h/%b exp %h/1", instr, instr_valid, mem[0]); end
  endtask

  task automatic test_halt_hold();
    clear_mem();
    mem[0] = mk(HALT, 5'd0, 12'h400);
    do_reset();
    instr_ready = 1'b0;
    do_start();
    tick();
    checks++; if (halted !== 1'b1 || instr !== mem[0] || instr_valid !== 1'b1) begin errors++; $display("FAIL hh_capture got %b/%h/%b exp 1/%h/1", halted, instr, instr_valid, mem[0]); end
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (instr !== mem[0] || instr_valid !== 1'b1 || pc !== 5'd0 || halted !== 1'b1) begin
        errors++; $display("FAIL hh_hold%0d got %h/%b/%0d/%b exp %h/1/0/1", i, instr, instr_valid, pc, halted, mem[0]);
      end
    end
    start = 1'b0; instr_ready = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b0 || issued !== 16'd1) begin errors++; $display("FAIL hh_accept got %b/%0d exp 0/1", instr_valid, issued); end
    tick();
    checks++; if (instr_valid !== 1'b0 || pc !== 5'd0 || halted !== 1'b1 || issued !== 16'd1) begin
      errors++; $display("FAIL hh_stay got %b/%0d/%b/%0d exp 0/0/1/1", instr_valid, pc, halted, issued);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
    clear_mem();
    test_reset();
    test_sequential();
    test_jump();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_halt_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
